// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: one CHUNK-bit slice per clock, ripple carry between slices.
// Valid/ready on both sides; the result holds in DONE until the consumer takes it.
module wide_add_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry_q;
    logic             cout_q;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   ch_sum;
    logic             last;

    // Slice select and write-back by index compare keeps part-selects constant.
    always_comb begin
        a_ch    = '0;
        b_ch    = '0;
        sum_nxt = sum_q;
        for (int k = 0; k < N; k++) begin
            if (idx == IW'(k)) begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
            end
        end
        ch_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        for (int k = 0; k < N; k++) begin
            if (idx == IW'(k)) begin
                sum_nxt[k*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
            end
        end
    end

    assign last = (idx == IW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx     <= '0;
            end
            if (state == CALC) begin
                sum_q   <= sum_nxt;
                carry_q <= ch_sum[CHUNK];
                idx     <= idx + IW'(1);
                if (last) cout_q <= ch_sum[CHUNK];
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed table plus corner sequences and a randomized back-to-back run
// across three slice widths (16, 8, 64) sharing one operand bus.
module tb_wide_add_seq;
    logic        clk;
    logic        rst_n;
    logic        iv     [3];
    logic        ordy   [3];
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        in_ready_o  [3];
    logic        out_valid_o [3];
    logic [63:0] sum_o       [3];
    logic        cout_o      [3];
    logic        busy_o      [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 16 : (g == 1) ? 8 : 64;
        wide_add_seq #(.WIDTH(64), .CHUNK(CH)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv[g]),
            .in_ready (in_ready_o[g]),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .out_valid(out_valid_o[g]),
            .out_ready(ordy[g]),
            .sum      (sum_o[g]),
            .cout     (cout_o[g]),
            .busy     (busy_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        c;
    } vec_t;

    vec_t vt [9];

    function automatic int nof(input int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : 1;
    endfunction

    task automatic chk(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input int k, input string nm);
        chk({nm, " in_ready"}, 65'(in_ready_o[k]), 65'd1);
        chk({nm, " out_valid"}, 65'(out_valid_o[k]), 65'd0);
        chk({nm, " busy"}, 65'(busy_o[k]), 65'd0);
        chk({nm, " sum"}, 65'(sum_o[k]), 65'd0);
        chk({nm, " cout"}, 65'(cout_o[k]), 65'd0);
    endtask

    // One operation with out_ready held high once the result appears.
    task automatic run_op(input int k, input logic [63:0] av,
                          input logic [63:0] bv, input logic cv,
                          output logic [63:0] s, output logic c,
                          output int lat, output int acc_wait,
                          output logic busy_ok);
        logic rdy;
        int   t0;
        int   guard;
        a = av;
        b = bv;
        cin = cv;
        iv[k] = 1'b1;
        acc_wait = 0;
        busy_ok = 1'b1;
        lat = -1;
        forever begin
            rdy = in_ready_o[k];
            tick();
            if (rdy || acc_wait > 50) break;
            acc_wait++;
        end
        iv[k] = 1'b0;
        a = ~av;
        b = ~bv;
        cin = ~cv;
        t0 = cyc;
        guard = 0;
        while (!out_valid_o[k] && guard < 100) begin
            if (!busy_o[k]) busy_ok = 1'b0;
            tick();
            guard++;
        end
        if (!busy_o[k]) busy_ok = 1'b0;
        if (out_valid_o[k]) lat = cyc - t0;
        s = sum_o[k];
        c = cout_o[k];
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
    endtask

    task automatic run_random(input int k, input int nops);
        logic [63:0] av, bv, s;
        logic        cv, c, rdy, hs, seen;
        logic [64:0] ref_v;
        int          nk, acc, prev_acc, wt, guard;
        nk = nof(k);
        prev_acc = -1;
        for (int op = 0; op < nops; op++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            cv = 1'($urandom_range(0, 1));
            if (op % 10 == 0) bv = ~av;
            ref_v = {1'b0, av} + {1'b0, bv} + {64'd0, cv};
            a = av;
            b = bv;
            cin = cv;
            iv[k] = 1'b1;
            wt = 0;
            forever begin
                rdy = in_ready_o[k];
                tick();
                if (rdy || wt > 50) break;
                wt++;
            end
            if (wt > 50) chk("rnd accept timeout", 65'(wt), 65'd0);
            acc = cyc;
            if (prev_acc >= 0 && (acc - prev_acc) < nk + 2)
                chk("rnd issue interval", 65'(acc - prev_acc), 65'(nk + 2));
            prev_acc = acc;
            seen = 1'b0;
            guard = 0;
            s = '0;
            c = 1'b0;
            forever begin
                if (out_valid_o[k] && !seen) begin
                    chk("rnd latency", 65'(cyc - acc), 65'(nk));
                    seen = 1'b1;
                end
                ordy[k] = 1'($urandom_range(0, 1));
                iv[k] = 1'($urandom_range(0, 1));
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                cin = 1'($urandom_range(0, 1));
                hs = out_valid_o[k] && ordy[k];
                if (hs) begin
                    s = sum_o[k];
                    c = cout_o[k];
                end
                tick();
                guard++;
                if (hs) break;
                if (guard > 200) begin
                    chk("rnd result timeout", 65'(guard), 65'd0);
                    break;
                end
            end
            iv[k] = 1'b0;
            ordy[k] = 1'b0;
            chk("rnd result", {c, s}, ref_v);
            chk("rnd no duplicate", 65'(out_valid_o[k]), 65'd0);
        end
    endtask

    initial begin
        logic [63:0] s, s0;
        logic        c, c0, bok;
        int          lat, aw, guard;

        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
        vt[1] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
                  64'h0000_0000_0001_0000, 1'b0};
        vt[2] = '{64'd0, 64'd0, 1'b1, 64'd1, 1'b0};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1};
        vt[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vt[5] = '{64'd5, 64'd7, 1'b0, 64'd12, 1'b0};
        vt[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                  64'd0, 1'b1};
        vt[8] = '{64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0,
                  64'h0001_0000_0000_0000, 1'b0};

        rst_n = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b0;
        end
        repeat (3) tick();
        for (int k = 0; k < 3; k++) chk_reset_vals(k, "reset");
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 9; i++) begin
                run_op(k, vt[i].a, vt[i].b, vt[i].cin, s, c, lat, aw, bok);
                chk("vec result", {c, s}, {vt[i].c, vt[i].s});
                chk("vec latency", 65'(lat), 65'(nof(k)));
                chk("vec busy", 65'(bok), 65'd1);
                chk("vec idle ready", 65'(in_ready_o[k]), 65'd1);
                chk("vec retained", {cout_o[k], sum_o[k]}, {vt[i].c, vt[i].s});
            end
        end

        // Backpressure: result must hold while new operands are offered.
        a = 64'h1111_2222_3333_4444;
        b = 64'hF000_0000_0000_0001;
        cin = 1'b1;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        guard = 0;
        while (!out_valid_o[0] && guard < 20) begin
            tick();
            guard++;
        end
        s0 = sum_o[0];
        c0 = cout_o[0];
        chk("bp result", {c0, s0}, {1'b1, 64'h0111_2222_3333_4446});
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            tick();
            chk("bp sum hold", 65'(sum_o[0]), 65'(s0));
            chk("bp cout hold", 65'(cout_o[0]), 65'(c0));
            chk("bp valid hold", 65'(out_valid_o[0]), 65'd1);
            chk("bp in_ready", 65'(in_ready_o[0]), 65'd0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        chk("bp back idle", 65'(in_ready_o[0]), 65'd1);
        chk("bp valid drop", 65'(out_valid_o[0]), 65'd0);
        chk("bp no capture", {cout_o[0], sum_o[0]}, {c0, s0});

        // Reset after two slice edges aborts the operation.
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'h1111_1111_1111_1111;
        cin = 1'b0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        chk("mid calc busy", 65'(busy_o[0]), 65'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals(0, "async reset");
        tick();
        chk_reset_vals(0, "held reset");
        rst_n = 1'b1;
        run_op(0, 64'd5, 64'd7, 1'b0, s, c, lat, aw, bok);
        chk("post reset accept wait", 65'(aw), 65'd0);
        chk("post reset result", {c, s}, {1'b0, 64'd12});
        chk("post reset latency", 65'(lat), 65'd4);

        for (int k = 0; k < 3; k++) run_random(k, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, 64, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, 16, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL NOT exceed WIDTH.
REQ-003 SHALL have a derived localparam N = WIDTH/CHUNK, the number of chunk cycles.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand set valid.
REQ-007 in_ready  output  1  block can accept an operand set.
REQ-008 a  input  WIDTH  operand A, unsigned.
REQ-009 b  input  WIDTH  operand B, unsigned.
REQ-010 cin  input  1  carry-in.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  registered result.
REQ-014 cout  output  1  registered carry-out.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 out_valid SHALL be 1 only in DONE.
REQ-019 Accept on edge t where in_valid=1 and in_ready=1:
  - register a, b and cin;
  - clear chunk index to 0;
  - move to CALC.
REQ-020 In CALC, each edge SHALL add chunk i of A, chunk i of B and the carry register.
  - Result goes to bits [i*CHUNK +: CHUNK] of the sum register.
  - Chunk carry-out goes to the carry register.
  - i increments by 1.
REQ-021 Chunk 0 SHALL use the captured cin as carry-in; chunk i>0 SHALL use the carry from chunk i-1.
REQ-022 Chunk i SHALL complete on edge t+1+i; the final chunk (i=N-1) SHALL complete on edge t+N.
  - On that edge, go to DONE.
  - cout takes the carry from chunk N-1.
  - out_valid is high from edge t+N onward.
REQ-023 Arithmetic: sum SHALL equal (a+b+cin) mod 2^WIDTH; cout SHALL equal bit WIDTH of (a+b+cin).
REQ-024 N=1 (CHUNK=WIDTH) SHALL work: CALC lasts exactly one cycle.
REQ-025 In DONE, sum, cout and out_valid SHALL hold stable until out_valid and out_ready are both 1 on an edge; the FSM then returns to IDLE.
REQ-026 sum and cout SHALL retain their last values after returning to IDLE, until overwritten by the next operation.
REQ-027 Minimum issue interval SHALL be N+2 cycles:
  - accept at t;
  - DONE handshake earliest at t+N+1;
  - next accept earliest at t+N+2.
REQ-028 in_valid in CALC or DONE SHALL be ignored (no capture, no state change).
REQ-029 Changes on a, b or cin after the accept edge SHALL NOT affect the in-flight result.
REQ-030 out_ready in IDLE or CALC SHALL have no effect.
REQ-031 The chunk index counter SHALL be ceil(log2(N+1)) bits wide and never wrap within an operation.

Reset
REQ-032 While rst_n=0, state SHALL be IDLE, with these output values:
  - in_ready=1;
  - out_valid=0;
  - busy=0;
  - sum=0;
  - cout=0.
  Internal operand, carry and index registers SHALL be 0.
REQ-033 Reset asserted mid-CALC or in DONE SHALL abort the operation immediately with no partial result visible; the first edge after rst_n rises SHALL be able to accept new operands.

Verification
REQ-034 WIDTH=64, CHUNK=16: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, accept at edge t -> out_valid rises at edge t+4, sum=0, cout=1, busy=1 over edges t+1..t+4.
REQ-035 Cross-chunk carry: a=0000_0000_0000_FFFF, b=0000_0000_0000_0001, cin=0 -> sum=0000_0000_0001_0000, cout=0; a=b=0, cin=1 -> sum=1, cout=0.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> sum, cout and out_valid are stable, in_ready=0, and no capture occurs; out_ready=1 -> IDLE next edge.
REQ-037 Reset mid-CALC after 2 chunk edges -> all outputs at reset values within the reset window; a subsequent op with a=5, b=7 gives sum=12 at the expected latency.
REQ-038 Random: 1000 back-to-back ops with random out_ready, for CHUNK in {8,16,64} -> each result matches reference (a+b+cin), every issue interval is >=N+2, and no result is lost or duplicated.
